// File: rtl/rollo_pkg.sv
// Shared types and helpers for the ROLLO run controller.
package rollo_pkg;

    // Run controller states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_READ,
        ST_FLUSH,
        ST_FIN
    } run_state_t;

    // Entries in the result skid buffer.
    localparam int SKID_DEPTH = 2;

    // Ceiling log2: clog2(1)=0, clog2(2)=1, clog2(5)=3.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Read-address width; never narrower than one bit so N_WORDS=1 still has a port.
    function automatic int addr_width(input int n_words);
        return (clog2(n_words) < 1) ? 1 : clog2(n_words);
    endfunction

endpackage

// File: rtl/rollo_skid_fifo.sv
// Two-entry valid/ready buffer carrying {last, data}; outputs hold while stalled.
module rollo_skid_fifo
    import rollo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    output logic [1:0]        count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int ENTRY_W = DATA_W + 1;

    logic [SKID_DEPTH-1:0][ENTRY_W-1:0] entry_q;
    logic                               wr_ptr_reg;
    logic                               rd_ptr_reg;
    logic [1:0]                         count_reg;
    logic [1:0]                         count_next;
    logic                               can_push;
    logic                               push;
    logic                               pop;

    // A full buffer may still take a word when the head leaves in the same cycle.
    assign can_push   = (count_reg != 2'(SKID_DEPTH)) || out_ready;
    assign push       = in_valid && can_push;
    assign out_valid  = (count_reg != 2'd0);
    assign pop        = out_valid && out_ready;
    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
    assign count      = count_reg;
    assign {out_last, out_data} = entry_q[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            // Each slot captures the incoming word only when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= {in_last, in_data};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rollo_run_ctrl.sv
// Run controller: launches a ROLLO core, times it, reads back its result and streams it out.
module rollo_run_ctrl
    import rollo_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_WORDS = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_start,
    output logic                               busy,
    output logic                               core_start,
    input  logic                               core_ready,
    output logic [addr_width(N_WORDS)-1:0]     core_raddr,
    input  logic [DATA_W-1:0]                  core_rdata,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic                               out_last,
    output logic [CNT_W-1:0]                   cycles,
    output logic                               timed_out,
    output logic                               done
);

    localparam int               ADDR_W       = addr_width(N_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_WORDS - 1);
    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT);

    run_state_t        state_reg;
    run_state_t        state_next;
    logic [CNT_W-1:0]  counter_reg;
    logic [CNT_W-1:0]  counter_next;
    logic [CNT_W-1:0]  counter_plus1;
    logic [CNT_W-1:0]  cycles_reg;
    logic [CNT_W-1:0]  cycles_next;
    logic              timed_out_reg;
    logic              timed_out_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;
    logic              ready_prev_reg;
    logic              inflight_reg;
    logic              inflight_last_reg;

    logic              ready_edge;
    logic              timeout_hit;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              issue;
    logic              issue_last;

    // Only a low-to-high transition counts, so a level left high by a previous run is ignored.
    assign ready_edge    = core_ready && !ready_prev_reg;
    assign counter_plus1 = (&counter_reg) ? counter_reg : counter_reg + CNT_W'(1);
    assign timeout_hit   = TIMEOUT_EN && (counter_reg == TIMEOUT_LAST);

    // Words held plus the read now in flight, less the one leaving this cycle; a new
    // address goes out only if its data will still find a free slot when it arrives.
    assign pop        = out_valid && out_ready;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue      = (state_reg == ST_READ) && (occupancy < 3'(SKID_DEPTH));
    assign issue_last = issue && (addr_reg == LAST_ADDR);

    assign busy       = (state_reg != ST_IDLE);
    assign core_start = (state_reg == ST_LAUNCH);
    assign done       = (state_reg == ST_FIN);
    assign core_raddr = addr_reg;
    assign cycles     = cycles_reg;
    assign timed_out  = timed_out_reg;

    // Next-state, latency counter, result latching and read-address sequencing.
    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        cycles_next    = cycles_reg;
        timed_out_next = timed_out_reg;
        addr_next      = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_start) begin
                    cycles_next    = '0;
                    timed_out_next = 1'b0;
                    state_next     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                counter_next = '0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                counter_next = counter_plus1;
                // A completion edge beats a timeout landing in the same cycle.
                if (ready_edge) begin
                    cycles_next = counter_plus1;
                    state_next  = ST_READ;
                end else if (timeout_hit) begin
                    cycles_next    = TIMEOUT_VAL;
                    timed_out_next = 1'b1;
                    state_next     = ST_FIN;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (issue_last) begin
                        addr_next  = '0;
                        state_next = ST_FLUSH;
                    end else begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && out_last) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            counter_reg   <= '0;
            cycles_reg    <= '0;
            timed_out_reg <= 1'b0;
            addr_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            cycles_reg    <= cycles_next;
            timed_out_reg <= timed_out_next;
            addr_reg      <= addr_next;
        end
    end

    // Ready history for edge detection and the one-deep read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_prev_reg    <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            ready_prev_reg    <= core_ready;
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
        end
    end

    rollo_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight_reg),
        .in_last  (inflight_last_reg),
        .in_data  (core_rdata),
        .count    (fifo_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_rollo_run_ctrl.sv
// Randomized bench for rollo_run_ctrl: an 8-word/TIMEOUT=100 build and a 1-word/no-timeout build
// share the command, core_ready and out_ready stimulus; each has its own result memory and scoreboard.
module tb_rollo_run_ctrl;

    localparam int A_TIMEOUT = 100;
    localparam int A_WORDS   = 8;

    logic        clk;
    logic        rst;
    logic        cmd_start;
    logic        core_ready;
    logic        out_ready;

    logic        busy_a, core_start_a, out_valid_a, out_last_a, timed_out_a, done_a;
    logic [2:0]  core_raddr_a;
    logic [31:0] core_rdata_a, out_data_a, cycles_a;

    logic        busy_b, core_start_b, out_valid_b, out_last_b, timed_out_b, done_b;
    logic [0:0]  core_raddr_b;
    logic [31:0] core_rdata_b, out_data_b, cycles_b;

    logic [31:0] rmem_a [A_WORDS];
    logic [31:0] rmem_b [1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit ignore_b = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    int exp_cyc_a, exp_cyc_b;
    bit exp_to_a;
    int cs_cnt_a, cs_cnt_b, done_cnt_a, done_cnt_b, done_cyc_a;
    int acc_a, first_v_a, last_acc_a;

    rollo_run_ctrl #(.DATA_W(32), .N_WORDS(A_WORDS), .CNT_W(32), .TIMEOUT(A_TIMEOUT)) dut_a (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy_a), .core_start(core_start_a),
        .core_ready(core_ready), .core_raddr(core_raddr_a), .core_rdata(core_rdata_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
        .cycles(cycles_a), .timed_out(timed_out_a), .done(done_a)
    );

    rollo_run_ctrl #(.DATA_W(32), .N_WORDS(1), .CNT_W(32), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy_b), .core_start(core_start_b),
        .core_ready(core_ready), .core_raddr(core_raddr_b), .core_rdata(core_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
        .cycles(cycles_b), .timed_out(timed_out_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Core result memories: read data appears one cycle after the address.
    initial begin
        forever begin
            @(posedge clk);
            core_rdata_a <= rmem_a[core_raddr_a];
            core_rdata_b <= rmem_b[core_raddr_b];
        end
    end

    // Stream sink readiness: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = (ph == 0) || (ph == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            ph = (ph + 1) % 4;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: latency is the cycle distance from launch to the ready edge, capped by the timeout.
    function automatic void model_a(input int lat, output int cyc_e, output bit to_e);
        if (lat <= A_TIMEOUT) begin
            cyc_e = lat;
            to_e  = 1'b0;
        end else begin
            cyc_e = A_TIMEOUT;
            to_e  = 1'b1;
        end
    endfunction

    // Monitor for the 8-word build.
    initial begin
        bit          held;
        logic [32:0] hold_word;
        logic [32:0] w;
        held = 0;
        hold_word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (core_start_a) cs_cnt_a++;
                if (held) begin
                    check_val("a_hold_valid", out_valid_a, 1);
                    check_val("a_hold_word", {out_last_a, out_data_a}, hold_word);
                end
                if (out_valid_a && first_v_a < 0) first_v_a = cyc;
                if (out_valid_a && out_ready) begin
                    acc_a++;
                    last_acc_a = cyc;
                    check_val("a_word_expected", exp_a.size() != 0, 1);
                    if (exp_a.size() != 0) begin
                        w = exp_a.pop_front();
                        check_val("a_word", {out_last_a, out_data_a}, w);
                    end
                end
                held = out_valid_a && !out_ready;
                hold_word = {out_last_a, out_data_a};
                if (done_a) begin
                    done_cnt_a++;
                    done_cyc_a = cyc;
                    check_val("a_cycles", cycles_a, exp_cyc_a);
                    check_val("a_timed_out", timed_out_a, exp_to_a);
                    check_val("a_words_left", exp_a.size(), 0);
                end
            end
        end
    end

    // Monitor for the 1-word build.
    initial begin
        bit          held;
        logic [32:0] hold_word;
        logic [32:0] w;
        held = 0;
        hold_word = '0;
        forever begin
            @(negedge clk);
            if (rst || ignore_b) begin
                held = 0;
            end else begin
                if (core_start_b) cs_cnt_b++;
                check_val("b_raddr", core_raddr_b, 0);
                if (held) begin
                    check_val("b_hold_word", {out_valid_b, out_last_b, out_data_b}, {1'b1, hold_word});
                end
                if (out_valid_b && out_ready) begin
                    check_val("b_word_expected", exp_b.size() != 0, 1);
                    if (exp_b.size() != 0) begin
                        w = exp_b.pop_front();
                        check_val("b_word", {out_last_b, out_data_b}, w);
                    end
                end
                held = out_valid_b && !out_ready;
                hold_word = {out_last_b, out_data_b};
                if (done_b) begin
                    done_cnt_b++;
                    check_val("b_cycles", cycles_b, exp_cyc_b);
                    check_val("b_timed_out", timed_out_b, 0);
                    check_val("b_words_left", exp_b.size(), 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One command: core_ready rises lat cycles after launch (stale: high before, low from +5).
    task automatic do_run(input int run_id, input int lat, input bit stale, input int rmode,
                          input bit pulse_cmd, input int rst_after);
        int  t0;
        int  i;
        bit  fin;
        bit  did_rst;
        ready_mode = rmode;
        ignore_b   = (rst_after > 0);
        for (int k = 0; k < A_WORDS; k++) rmem_a[k] = $urandom;
        rmem_b[0] = $urandom;
        model_a(lat, exp_cyc_a, exp_to_a);
        exp_cyc_b = lat;
        exp_a.delete();
        exp_b.delete();
        if (!exp_to_a) begin
            for (int k = 0; k < A_WORDS; k++) exp_a.push_back({(k == A_WORDS - 1) ? 1'b1 : 1'b0, rmem_a[k]});
        end
        exp_b.push_back({1'b1, rmem_b[0]});
        cs_cnt_a = 0; cs_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        acc_a = 0; first_v_a = -1; last_acc_a = -1; done_cyc_a = -1;
        core_ready = stale;
        idle(2);
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        @(negedge clk);
        t0 = cyc;
        check_val("a_launch", {busy_a, core_start_a}, 2'b11);
        check_val("b_launch", {busy_b, core_start_b}, 2'b11);
        check_val("a_cleared", {cycles_a, timed_out_a}, 33'd0);
        i = 0;
        fin = 0;
        did_rst = 0;
        while (!fin) begin
            @(posedge clk);
            #1;
            i++;
            if (stale && i < 5) core_ready = 1'b1;
            else core_ready = (i >= lat);
            cmd_start = pulse_cmd && (i == 10);
            if (rst_after > 0 && acc_a >= rst_after) begin
                rst = 1'b1;
                core_ready = 1'b0;
                cmd_start = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check_val("rst_busy", busy_a, 0);
                check_val("rst_out_valid", out_valid_a, 0);
                check_val("rst_cycles", cycles_a, 0);
                check_val("rst_done", done_a, 0);
                exp_a.delete();
                exp_b.delete();
                did_rst = 1;
                fin = 1;
            end else if (done_cnt_a > 0 && done_cnt_b > 0) begin
                fin = 1;
            end else if (i > 1000) begin
                check_val("run_completed", {done_cnt_a > 0, done_cnt_b > 0}, 2'b11);
                fin = 1;
            end
        end
        core_ready = 1'b0;
        cmd_start  = 1'b0;
        idle(4);
        check_val("a_one_launch", cs_cnt_a, 1);
        if (did_rst) begin
            check_val("rst_no_done", done_cnt_a, 0);
        end else begin
            check_val("b_one_launch", cs_cnt_b, 1);
            check_val("a_one_done", done_cnt_a, 1);
            check_val("b_one_done", done_cnt_b, 1);
            if (exp_to_a) begin
                check_val("a_timeout_done_cycle", done_cyc_a, t0 + A_TIMEOUT + 1);
                check_val("a_timeout_no_stream", first_v_a, -1);
            end else if (rmode == 0) begin
                check_val("a_throughput", last_acc_a - first_v_a + 1, A_WORDS);
            end
        end
        ignore_b = 0;
        $display("run %0d: lat=%0d stale=%0b ready_mode=%0d cmd_pulse=%0b rst_after=%0d a_cycles=%0d a_timed_out=%0b b_cycles=%0d",
                 run_id, lat, stale, rmode, pulse_cmd, rst_after, cycles_a, timed_out_a, cycles_b);
    endtask

    initial begin
        int lat;
        bit stale;
        rst = 1'b1;
        cmd_start = 1'b0;
        core_ready = 1'b0;
        for (int k = 0; k < A_WORDS; k++) rmem_a[k] = '0;
        rmem_b[0] = '0;
        idle(3);
        @(negedge clk);
        check_val("reset_ctrl", {busy_a, core_start_a, done_a, timed_out_a}, 4'b0000);
        check_val("reset_stream", {out_valid_a, out_last_a, out_data_a}, 34'd0);
        check_val("reset_raddr_cycles", {core_raddr_a, cycles_a}, 35'd0);
        check_val("reset_b", {busy_b, out_valid_b, out_last_b, cycles_b}, 35'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        do_run(1, 37, 0, 0, 0, 0);
        do_run(2, 12, 0, 1, 0, 0);
        do_run(3, 150, 0, 0, 0, 0);
        do_run(4, 100, 0, 2, 0, 0);
        do_run(5, 101, 0, 1, 0, 0);
        do_run(6, 20, 1, 0, 0, 0);
        do_run(7, 30, 0, 2, 1, 0);
        do_run(8, 15, 0, 0, 0, 3);
        do_run(9, 25, 0, 0, 0, 0);
        for (int r = 0; r < 12; r++) begin
            lat   = $urandom_range(6, 130);
            stale = 1'($urandom_range(0, 1));
            do_run(10 + r, lat, stale, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
